pipe_rr_arbiter: RTL and testbench
==================================

Name: pipe_rr_arbiter

Overview:
- Shares one elastic valid/ready datapath pipeline (`W`-bit payload, no sideband) between `N` requesters.
- Arbitrates round-robin on the input side.
- Records each accepted item's requester index in an in-order tag FIFO.
- Steers each pipeline output back to its owning requester's response port.
- Sits between requester clients and the pipeline's pipe_in/pipe_out handshake ports.

Parameters:
- `N`, 3: number of requesters (2..8).
- `W`, 5: payload width, matching the pipeline data width.
- `DEPTH`, 8: tag FIFO depth, i.e. the maximum number of items in flight. Must be ≥ pipeline stage count for full throughput. Power of two.

Ports:
- `clk_i`  in  1  clock
- `reset_ni`  in  1  asynchronous active-low reset
- `req_valid_i`  in  N  per-requester request valid
- `req_data_i`  in  N*W  per-requester payload; requester k occupies bits [k*W +: W]
- `req_rdy_o`  out  N  per-requester accept
- `pipe_in_val_o`  out  W  payload to pipeline
- `pipe_in_valid_o`  out  1  valid to pipeline
- `pipe_in_rdy_i`  in  1  pipeline input ready
- `pipe_out_val_i`  in  W  pipeline result
- `pipe_out_valid_i`  in  1  pipeline result valid
- `pipe_out_rdy_o`  out  1  ready to pipeline
- `rsp_val_o`  out  W  result payload, shared by all requesters
- `rsp_valid_o`  out  N  one-hot result valid
- `rsp_rdy_i`  in  N  per-requester result ready
- `inflight_o`  out  $clog2(DEPTH)+1  tag FIFO occupancy
- `err_o`  out  1  sticky protocol error

Behaviour:
- Interface decision: one clock `clk_i`; reset `reset_ni` is asynchronous and active-low. All flops clear immediately on `reset_ni`=0.
- Reset state:
  - outputs: `req_rdy_o`=0, `pipe_in_valid_o`=0, `pipe_out_rdy_o`=0, `rsp_valid_o`=0, `inflight_o`=0, `err_o`=0;
  - internal: priority pointer=0, lock=0, FIFO empty.
- Requester rule: once `req_valid_i[k]`=1, it stays high with stable data until `req_rdy_o[k]`=1.
- Arbitration, two states:
  - **IDLE (lock=0):** candidate is the first k with `req_valid_i[k]`=1, searching pointer, pointer+1, … mod N.
  - **LOCKED (lock=1):** candidate = held grant index.
  - Offer condition: a candidate exists and FIFO count < `DEPTH`.
  - `pipe_in_valid_o`=1 iff offering; `pipe_in_val_o` = candidate's data.
  - `req_rdy_o[cand]` = `pipe_in_rdy_i` & offering; all other `req_rdy_o` bits 0.
- Transitions:
  - Offered, not accepted (`pipe_in_rdy_i`=0): go to LOCKED with that index. `pipe_in_valid_o` never drops and data never changes while unaccepted.
  - Accepted (handshake): lock=0; pointer = (cand+1) mod N; push cand into FIFO.
  - No combinational path from `pipe_in_rdy_i` to `pipe_in_valid_o`.
- Full: FIFO count == `DEPTH` → no offer. No same-cycle pop bypass; offering resumes the cycle after a pop.
  - Lock cannot occur while full, because an offer requires count < `DEPTH`.
- Output steering:
  - head = FIFO oldest tag.
  - If FIFO is non-empty: `rsp_valid_o[head]` = `pipe_out_valid_i`, `rsp_val_o` = `pipe_out_val_i`, `pipe_out_rdy_o` = `rsp_rdy_i[head]`.
  - If FIFO is empty: `rsp_valid_o`=0 and `pipe_out_rdy_o`=0.
  - Pop on `pipe_out_valid_i` & `pipe_out_rdy_o`.
  - Output path is combinational (zero added latency). Round-trip latency = pipeline latency.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Pointer wrap: FIFO read/write pointers wrap mod `DEPTH`.
- Error: `pipe_out_valid_i`=1 while FIFO empty sets `err_o`=1 until reset; the item is not consumed.
- Reset mid-operation: all in-flight tags are discarded. The system resets the pipeline on the same reset so no orphan results emerge.
- Ordering: results return strictly in acceptance order, which the in-order pipeline guarantees.

Test Plan:
- **Round-robin rotation:** N=3; all `req_valid_i`=3'b111, data 1/2/3; `pipe_in_rdy_i`=1 → accepts in order 0,1,2,0,…; results route to `rsp_valid_o` 001, 010, 100 with values 1, 2, 3.
- **Stall lock:** only req0 valid (data 7); `pipe_in_rdy_i`=0 for 4 cycles; req1 raised at cycle 2 → `pipe_in_val_o` stays 7; req0 accepted when ready rises; req1 accepted next cycle.
- **Full:** `DEPTH`=8, `pipe_out_rdy` path blocked via `rsp_rdy_i`=0 → exactly 8 accepts, `inflight_o`=8, `pipe_in_valid_o`=0; set `rsp_rdy_i[head]`=1 for one pop → `inflight_o`=7, one new accept the next cycle.
- **Simultaneous push/pop:** at steady state with count 5 → count stays 5 across 20 cycles of back-to-back traffic; no drops or duplicates (scoreboard).
- **Response backpressure:** head owner 2 has `rsp_rdy_i[2]`=0 → `pipe_out_rdy_o`=0; other requesters' `rsp_rdy_i` are ignored; release → delivery to 2.
- **Error and reset:** `pipe_out_valid_i`=1 with FIFO empty → `err_o`=1 and sticky; assert `reset_ni`=0 mid-traffic → all outputs 0 immediately, `inflight_o`=0, pointer restarts at requester 0.

Source files
------------

// File: rtl/pipe_rr_arbiter.sv
// Round-robin front end for a shared elastic valid/ready pipeline.
// Grants one of N requesters per accepted item, remembers each item's owner
// in an in-order tag FIFO, and steers pipeline results back to that owner.
module pipe_rr_arbiter #(
    parameter int unsigned N     = 3,
    parameter int unsigned W     = 5,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [N-1:0]             req_valid_i,
    input  logic [N*W-1:0]           req_data_i,
    output logic [N-1:0]             req_rdy_o,
    output logic [W-1:0]             pipe_in_val_o,
    output logic                     pipe_in_valid_o,
    input  logic                     pipe_in_rdy_i,
    input  logic [W-1:0]             pipe_out_val_i,
    input  logic                     pipe_out_valid_i,
    output logic                     pipe_out_rdy_o,
    output logic [W-1:0]             rsp_val_o,
    output logic [N-1:0]             rsp_valid_o,
    input  logic [N-1:0]             rsp_rdy_i,
    output logic [$clog2(DEPTH):0]   inflight_o,
    output logic                     err_o
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    arb_state_e     state_q;
    logic [IW-1:0]  held_q;
    logic [IW-1:0]  ptr_q;

    logic [IW-1:0]  tag_mem [DEPTH];
    logic [AW-1:0]  wr_ptr_q;
    logic [AW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;
    logic           err_q;

    logic           cand_found;
    logic [IW-1:0]  cand_idx;
    logic [IW:0]    search_idx;
    logic [W-1:0]   cand_data;
    logic [IW-1:0]  ptr_next;
    logic           not_full;
    logic           fifo_empty;
    logic           offer;
    logic           accept;
    logic           pop;
    logic [IW-1:0]  head;

    // Pick the candidate: the held index while locked, else first valid from the pointer
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        search_idx = '0;
        if (state_q == ARB_LOCKED) begin
            cand_found = 1'b1;
            cand_idx   = held_q;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                search_idx = (IW+1)'(ptr_q) + (IW+1)'(i);
                if (search_idx >= (IW+1)'(N)) begin
                    search_idx = search_idx - (IW+1)'(N);
                end
                if (!cand_found && req_valid_i[search_idx[IW-1:0]]) begin
                    cand_found = 1'b1;
                    cand_idx   = search_idx[IW-1:0];
                end
            end
        end
    end

    // Offer/accept handshake toward the pipeline and payload mux
    always_comb begin
        cand_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (IW'(i) == cand_idx) begin
                cand_data = req_data_i[i*W +: W];
            end
        end
        not_full        = (count_q < CW'(DEPTH));
        // Gated by reset so every output reads zero while reset is held
        offer           = reset_ni && cand_found && not_full;
        accept          = offer && pipe_in_rdy_i;
        pipe_in_valid_o = offer;
        pipe_in_val_o   = offer ? cand_data : '0;
        for (int unsigned i = 0; i < N; i++) begin
            req_rdy_o[i] = accept && (IW'(i) == cand_idx);
        end
        ptr_next = (cand_idx == IW'(N - 1)) ? '0 : cand_idx + 1'b1;
    end

    // Steer the pipeline result to the owner of the oldest in-flight tag
    always_comb begin
        fifo_empty     = (count_q == '0);
        head           = tag_mem[rd_ptr_q];
        pipe_out_rdy_o = !fifo_empty && rsp_rdy_i[head];
        rsp_val_o      = fifo_empty ? '0 : pipe_out_val_i;
        for (int unsigned i = 0; i < N; i++) begin
            rsp_valid_o[i] = !fifo_empty && pipe_out_valid_i && (IW'(i) == head);
        end
        pop        = pipe_out_valid_i && pipe_out_rdy_o;
        inflight_o = count_q;
        err_o      = err_q;
    end

    // Arbitration FSM: lock on an unaccepted offer, rotate the pointer on accept
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ARB_IDLE;
            held_q  <= '0;
            ptr_q   <= '0;
        end else if (accept) begin
            state_q <= ARB_IDLE;
            ptr_q   <= ptr_next;
        end else if (offer) begin
            state_q <= ARB_LOCKED;
            held_q  <= cand_idx;
        end
    end

    // Tag FIFO bookkeeping and sticky error on a result with nothing in flight
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                tag_mem[wr_ptr_q] <= cand_idx;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (pipe_out_valid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Directed bench for pipe_rr_arbiter with a queue-based pipeline model and
// a scoreboard pairing every accepted request with its routed response.
module tb_pipe_rr_arbiter;

    localparam int N     = 3;
    localparam int W     = 5;
    localparam int DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   reset_ni;
    logic [N-1:0]           req_valid_i;
    logic [N*W-1:0]         req_data_i;
    logic [N-1:0]           req_rdy_o;
    logic [W-1:0]           pipe_in_val_o;
    logic                   pipe_in_valid_o;
    logic                   pipe_in_rdy_i;
    logic [W-1:0]           pipe_out_val_i;
    logic                   pipe_out_valid_i;
    logic                   pipe_out_rdy_o;
    logic [W-1:0]           rsp_val_o;
    logic [N-1:0]           rsp_valid_o;
    logic [N-1:0]           rsp_rdy_i;
    logic [$clog2(DEPTH):0] inflight_o;
    logic                   err_o;

    always #5 clk = ~clk;

    pipe_rr_arbiter #(.N(N), .W(W), .DEPTH(DEPTH)) dut (
        .clk_i            (clk),
        .reset_ni         (reset_ni),
        .req_valid_i      (req_valid_i),
        .req_data_i       (req_data_i),
        .req_rdy_o        (req_rdy_o),
        .pipe_in_val_o    (pipe_in_val_o),
        .pipe_in_valid_o  (pipe_in_valid_o),
        .pipe_in_rdy_i    (pipe_in_rdy_i),
        .pipe_out_val_i   (pipe_out_val_i),
        .pipe_out_valid_i (pipe_out_valid_i),
        .pipe_out_rdy_o   (pipe_out_rdy_o),
        .rsp_val_o        (rsp_val_o),
        .rsp_valid_o      (rsp_valid_o),
        .rsp_rdy_i        (rsp_rdy_i),
        .inflight_o       (inflight_o),
        .err_o            (err_o)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pipeline model and scoreboard state
    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } exp_t;

    logic [W-1:0] pq[$];
    exp_t         sb[$];
    int           acc_log[$];
    int           resp_cnt = 0;
    logic         in_hs_q = 1'b0;
    logic         out_hs_q = 1'b0;
    logic [W-1:0] in_data_q = '0;
    int           pq_n = 0;
    logic [W-1:0] pq_head = '0;
    logic         pipe_out_en = 1'b0;
    logic         force_err = 1'b0;
    int           mon_idx;
    exp_t         mon_e;

    assign pipe_out_valid_i = force_err | (pipe_out_en & (pq_n > 0));
    assign pipe_out_val_i   = pq_head;

    // Mid-cycle monitor: record handshakes that complete at the next rising edge
    always @(negedge clk) begin
        in_hs_q   = pipe_in_valid_o && pipe_in_rdy_i;
        out_hs_q  = pipe_out_valid_i && pipe_out_rdy_o;
        in_data_q = pipe_in_val_o;
        if (out_hs_q) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk("rsp_route", rsp_valid_o, 1 << mon_e.idx);
                chk("rsp_value", rsp_val_o, mon_e.data);
                resp_cnt++;
            end
        end
        if (in_hs_q) begin
            chk("accept_onehot", $countones(req_rdy_o), 1);
            mon_idx = -1;
            for (int k = 0; k < N; k++) begin
                if (req_rdy_o[k]) mon_idx = k;
            end
            if (mon_idx >= 0) begin
                chk("accept_data", pipe_in_val_o, req_data_i[mon_idx*W +: W]);
                sb.push_back('{mon_idx, req_data_i[mon_idx*W +: W]});
                acc_log.push_back(mon_idx);
            end
        end
    end

    // Pipeline model: in-order queue, flushed with the shared reset
    always @(posedge clk) begin
        #1;
        if (!reset_ni) begin
            pq.delete();
            sb.delete();
        end else begin
            if (out_hs_q && pq.size() > 0) void'(pq.pop_front());
            if (in_hs_q) pq.push_back(in_data_q);
        end
        in_hs_q  = 1'b0;
        out_hs_q = 1'b0;
        pq_n     = pq.size();
        pq_head  = (pq.size() > 0) ? pq[0] : '0;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_inflight(input int target, input int limit, input string tag);
        for (int c = 0; c < limit && int'(inflight_o) != target; c++) tick();
        chk(tag, inflight_o, target);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n0;

    initial begin
        reset_ni      = 1'b0;
        req_valid_i   = '0;
        req_data_i    = '0;
        pipe_in_rdy_i = 1'b0;
        rsp_rdy_i     = '0;
        repeat (2) tick();

        // Reset state
        chk("rst_req_rdy", req_rdy_o, 0);
        chk("rst_in_valid", pipe_in_valid_o, 0);
        chk("rst_out_rdy", pipe_out_rdy_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_inflight", inflight_o, 0);
        chk("rst_err", err_o, 0);
        reset_ni = 1'b1;
        tick();

        // Round-robin rotation with results held back, then drained
        pipe_in_rdy_i = 1'b1;
        rsp_rdy_i     = 3'b111;
        pipe_out_en   = 1'b0;
        req_data_i    = {5'd3, 5'd2, 5'd1};
        req_valid_i   = 3'b111;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("rr_grant", req_rdy_o, 1 << (i % 3));
            chk("rr_data", pipe_in_val_o, (i % 3) + 1);
            tick();
        end
        req_valid_i = '0;
        chk("rr_inflight", inflight_o, 6);
        pipe_out_en = 1'b1;
        #1;
        chk("rr_first_rsp_valid", rsp_valid_o, 3'b001);
        chk("rr_first_rsp_val", rsp_val_o, 1);
        chk("rr_first_out_rdy", pipe_out_rdy_o, 1);
        wait_inflight(0, 20, "rr_drain");
        chk("rr_resp_cnt", resp_cnt, 6);

        // Stall lock: offer held stable while the pipeline is not ready
        pipe_out_en   = 1'b0;
        pipe_in_rdy_i = 1'b0;
        req_data_i    = {5'd6, 5'd9, 5'd7};
        req_valid_i   = 3'b001;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) req_valid_i = 3'b011;
            #1;
            chk("lock_valid", pipe_in_valid_o, 1);
            chk("lock_data", pipe_in_val_o, 7);
            chk("lock_no_rdy", req_rdy_o, 0);
            tick();
        end
        pipe_in_rdy_i = 1'b1;
        #1;
        chk("lock_grant0", req_rdy_o, 3'b001);
        tick();
        req_valid_i = 3'b010;
        #1;
        chk("lock_grant1", req_rdy_o, 3'b010);
        chk("lock_data1", pipe_in_val_o, 9);
        tick();
        req_valid_i = '0;
        chk("lock_inflight", inflight_o, 2);

        // Lock must outrank a requester that would win a fresh search (pointer is 2)
        pipe_in_rdy_i = 1'b0;
        req_data_i    = {5'd6, 5'd9, 5'd4};
        req_valid_i   = 3'b001;
        #1;
        chk("lock2_data", pipe_in_val_o, 4);
        tick();
        req_valid_i = 3'b101;
        #1;
        chk("lock2_hold", pipe_in_val_o, 4);
        chk("lock2_no_rdy", req_rdy_o, 0);
        tick();
        pipe_in_rdy_i = 1'b1;
        #1;
        chk("lock2_grant0", req_rdy_o, 3'b001);
        tick();
        req_valid_i = 3'b100;
        #1;
        chk("lock2_grant2", req_rdy_o, 3'b100);
        chk("lock2_data2", pipe_in_val_o, 6);
        tick();
        req_valid_i = '0;
        pipe_out_en = 1'b1;
        wait_inflight(0, 20, "lock_drain");

        // Full: responses blocked, exactly DEPTH accepts
        rsp_rdy_i   = '0;
        req_data_i  = {5'd3, 5'd2, 5'd1};
        req_valid_i = 3'b111;
        n0          = acc_log.size();
        repeat (10) tick();
        chk("full_accepts", acc_log.size() - n0, 8);
        chk("full_inflight", inflight_o, 8);
        chk("full_no_offer", pipe_in_valid_o, 0);
        chk("full_no_rdy", req_rdy_o, 0);
        rsp_rdy_i = 3'b001;
        #1;
        chk("full_pop_rdy", pipe_out_rdy_o, 1);
        chk("full_pop_valid", rsp_valid_o, 3'b001);
        chk("full_no_bypass", pipe_in_valid_o, 0);
        tick();
        rsp_rdy_i = '0;
        #1;
        chk("full_after_pop", inflight_o, 7);
        chk("full_resume", pipe_in_valid_o, 1);
        chk("full_resume_grant", req_rdy_o, 3'b100);
        tick();
        chk("full_refill", inflight_o, 8);
        chk("full_one_more", acc_log.size() - n0, 9);
        req_valid_i = '0;
        rsp_rdy_i   = 3'b111;
        wait_inflight(0, 30, "full_drain");

        // Simultaneous push/pop at a steady occupancy of 5
        rsp_rdy_i   = '0;
        req_valid_i = 3'b111;
        wait_inflight(5, 10, "pp_fill");
        rsp_rdy_i = 3'b111;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("pp_count", inflight_o, 5);
        end
        req_valid_i = '0;
        wait_inflight(0, 20, "pp_drain");
        chk("pp_balance", resp_cnt, acc_log.size());

        // Response backpressure: only the head owner's ready matters
        rsp_rdy_i   = '0;
        req_data_i  = {5'd5, 5'd0, 5'd8};
        req_valid_i = 3'b100;
        tick();
        req_valid_i = 3'b001;
        tick();
        req_valid_i = '0;
        chk("bp_inflight", inflight_o, 2);
        rsp_rdy_i = 3'b011;
        #1;
        chk("bp_valid", rsp_valid_o, 3'b100);
        chk("bp_val", rsp_val_o, 5);
        chk("bp_blocked", pipe_out_rdy_o, 0);
        tick();
        tick();
        chk("bp_held", inflight_o, 2);
        rsp_rdy_i = 3'b100;
        #1;
        chk("bp_release", pipe_out_rdy_o, 1);
        tick();
        chk("bp_next_valid", rsp_valid_o, 3'b001);
        chk("bp_next_blocked", pipe_out_rdy_o, 0);
        chk("bp_after", inflight_o, 1);
        rsp_rdy_i = 3'b001;
        wait_inflight(0, 10, "bp_drain");

        // Error: result valid with nothing in flight, sticky
        force_err = 1'b1;
        #1;
        chk("err_rsp_valid", rsp_valid_o, 0);
        chk("err_out_rdy", pipe_out_rdy_o, 0);
        chk("err_not_yet", err_o, 0);
        tick();
        force_err = 1'b0;
        chk("err_set", err_o, 1);
        repeat (3) tick();
        chk("err_sticky", err_o, 1);

        // Reset mid-traffic
        req_data_i  = {5'd3, 5'd2, 5'd1};
        req_valid_i = 3'b111;
        rsp_rdy_i   = '0;
        repeat (3) tick();
        chk("pre_reset_inflight", inflight_o, 3);
        reset_ni = 1'b0;
        #1;
        chk("mid_rst_req_rdy", req_rdy_o, 0);
        chk("mid_rst_in_valid", pipe_in_valid_o, 0);
        chk("mid_rst_in_val", pipe_in_val_o, 0);
        chk("mid_rst_out_rdy", pipe_out_rdy_o, 0);
        chk("mid_rst_rsp_valid", rsp_valid_o, 0);
        chk("mid_rst_rsp_val", rsp_val_o, 0);
        chk("mid_rst_inflight", inflight_o, 0);
        chk("mid_rst_err", err_o, 0);
        tick();
        tick();
        reset_ni = 1'b1;
        #1;
        chk("rst_ptr_grant", pipe_in_valid_o, 1);
        chk("rst_ptr_data", pipe_in_val_o, 1);
        rsp_rdy_i = 3'b111;
        pipe_in_rdy_i = 1'b1;
        #1;
        chk("rst_ptr_rdy", req_rdy_o, 3'b001);
        tick();
        req_valid_i = '0;
        wait_inflight(0, 10, "final_drain");
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
